id_ex_stage: RTL

- Pipeline register between decode (register-file read) and execute in the 16-bit pipelined CPU.
- Captures decoded operands and control each cycle.
- Detects load-use hazards against the instruction currently in EX and raises Stall to freeze PC and IF/ID.
- Inserts bubbles on stall or branch flush.

---
 rtl/id_ex_stage_if.sv | 45 ++++
 rtl/id_ex_stage.sv | 66 ++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side operands/control in, execute-side registered fields and stall out
interface id_ex_stage_if #(
  parameter int DSIZE = 16,
  parameter int RSIZE = 4,
  parameter int CSIZE = 8
);
  logic             Flush;
  logic             ID_Valid;
  logic [RSIZE-1:0] ID_RAddr1;
  logic [RSIZE-1:0] ID_RAddr2;
  logic             ID_Uses1;
  logic             ID_Uses2;
  logic [RSIZE-1:0] ID_WAddr;
  logic             ID_Wen;
  logic             ID_MemRead;
  logic             ID_MemWrite;
  logic [DSIZE-1:0] ID_RData1;
  logic [DSIZE-1:0] ID_RData2;
  logic [DSIZE-1:0] ID_Imm;
  logic [CSIZE-1:0] ID_Ctrl;
  logic             Stall;
  logic             EX_Valid;
  logic             EX_Wen;
  logic             EX_MemRead;
  logic             EX_MemWrite;
  logic [RSIZE-1:0] EX_RAddr1;
  logic [RSIZE-1:0] EX_RAddr2;
  logic [RSIZE-1:0] EX_WAddr;
  logic [DSIZE-1:0] EX_RData1;
  logic [DSIZE-1:0] EX_RData2;
  logic [DSIZE-1:0] EX_Imm;
  logic [CSIZE-1:0] EX_Ctrl;
  modport master (
    output Flush, ID_Valid, ID_RAddr1, ID_RAddr2, ID_Uses1, ID_Uses2, ID_WAddr, ID_Wen,
           ID_MemRead, ID_MemWrite, ID_RData1, ID_RData2, ID_Imm, ID_Ctrl,
    input  Stall, EX_Valid, EX_Wen, EX_MemRead, EX_MemWrite, EX_RAddr1, EX_RAddr2, EX_WAddr,
           EX_RData1, EX_RData2, EX_Imm, EX_Ctrl
  );
  modport slave (
    input  Flush, ID_Valid, ID_RAddr1, ID_RAddr2, ID_Uses1, ID_Uses2, ID_WAddr, ID_Wen,
           ID_MemRead, ID_MemWrite, ID_RData1, ID_RData2, ID_Imm, ID_Ctrl,
    output Stall, EX_Valid, EX_Wen, EX_MemRead, EX_MemWrite, EX_RAddr1, EX_RAddr2, EX_WAddr,
           EX_RData1, EX_RData2, EX_Imm, EX_Ctrl
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall and flush bubbles; ID_EX_STALL_COUNT_EN adds stall/bubble counters
module id_ex_stage #(
  parameter int DSIZE = 16,
  parameter int RSIZE = 4,
  parameter int CSIZE = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  id_ex_stage_if.slave bus
`ifdef ID_EX_STALL_COUNT_EN
  ,
  output logic [15:0] StallCount,
  output logic [15:0] BubbleCount
`endif
);
  logic haz;
  logic bubble;
  // load in EX whose nonzero destination is read by the instruction in decode; flush overrides the stall
  always_comb begin
    haz = bus.EX_Valid & bus.EX_MemRead & (bus.EX_WAddr != '0) & bus.ID_Valid &
          ((bus.ID_Uses1 & (bus.ID_RAddr1 == bus.EX_WAddr)) |
           (bus.ID_Uses2 & (bus.ID_RAddr2 == bus.EX_WAddr)));
    bus.Stall = haz & ~bus.Flush;
    bubble = bus.Flush | bus.Stall | ~bus.ID_Valid;
  end
  // capture decode fields or load an all-zero bubble
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bus.EX_Valid    <= 1'b0;
      bus.EX_Wen      <= 1'b0;
      bus.EX_MemRead  <= 1'b0;
      bus.EX_MemWrite <= 1'b0;
      bus.EX_RAddr1   <= {RSIZE{1'b0}};
      bus.EX_RAddr2   <= {RSIZE{1'b0}};
      bus.EX_WAddr    <= {RSIZE{1'b0}};
      bus.EX_RData1   <= {DSIZE{1'b0}};
      bus.EX_RData2   <= {DSIZE{1'b0}};
      bus.EX_Imm      <= {DSIZE{1'b0}};
      bus.EX_Ctrl     <= {CSIZE{1'b0}};
    end else begin
      bus.EX_Valid    <= ~bubble;
      bus.EX_Wen      <= ~bubble & bus.ID_Wen & (bus.ID_WAddr != '0);
      bus.EX_MemRead  <= ~bubble & bus.ID_MemRead;
      bus.EX_MemWrite <= ~bubble & bus.ID_MemWrite;
      bus.EX_RAddr1   <= bubble ? {RSIZE{1'b0}} : bus.ID_RAddr1;
      bus.EX_RAddr2   <= bubble ? {RSIZE{1'b0}} : bus.ID_RAddr2;
      bus.EX_WAddr    <= bubble ? {RSIZE{1'b0}} : bus.ID_WAddr;
      bus.EX_RData1   <= bubble ? {DSIZE{1'b0}} : bus.ID_RData1;
      bus.EX_RData2   <= bubble ? {DSIZE{1'b0}} : bus.ID_RData2;
      bus.EX_Imm      <= bubble ? {DSIZE{1'b0}} : bus.ID_Imm;
      bus.EX_Ctrl     <= bubble ? {CSIZE{1'b0}} : bus.ID_Ctrl;
    end
  end
`ifdef ID_EX_STALL_COUNT_EN
  // saturating counts of stall edges and bubble loads
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      StallCount  <= 16'h0;
      BubbleCount <= 16'h0;
    end else begin
      StallCount  <= StallCount + 16'(bus.Stall & ~&StallCount);
      BubbleCount <= BubbleCount + 16'(bubble & ~&BubbleCount);
    end
  end
`endif
endmodule
